interleaver_sequencer: RTL and testbench
========================================

Name: interleaver_sequencer

Overview:
- Controller that sequences one junction pass through interleaver_set.
- Holds the per-sweep start pattern (sweepstart), loaded over a chunk-serial config port, so the interleaver no longer self-initialises on reset.
- On start, issues cycle_index 0 .. fo*p/z-1 under a valid/ready handshake with sweep-boundary flags, then pulses done.
- Sits between the layer/junction FSM and the interleaver + activation-memory read port.

Parameters:
- fo, 2, fan-out of the left-hand layer
- fi, 4, fan-in of the right-hand layer (carried for consistency, unused internally)
- p, 32, left-hand neurons in the junction
- n, 8, right-hand neurons in the junction (carried, unused)
- z, 8, weights processed per cycle; p/z must be a power of 2 and >= 2

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-low reset (reset==0 resets on the rising clk edge)
- cfg_valid  input  1  config chunk present
- cfg_data  input  $clog2(p/z)  one sweepstart chunk
- cfg_ready  output  1  config chunk accepted this cycle (1 only in IDLE)
- cfg_loaded  output  1  all fo*z chunks written since the last chunk-0 write
- sweepstart  output  $clog2(p/z)*fo*z  packed pattern to interleaver_set; chunk k at bits [k*SW +: SW]
- start  input  1  request a junction pass
- start_err  output  1  one-cycle pulse: start received while cfg_loaded==0
- busy  output  1  state==RUN
- cycle_index  output  $clog2(fo*p/z)  to interleaver_set
- cycle_valid  output  1  cycle_index is valid
- cycle_ready  input  1  consumer accepts cycle_index
- sweep_index  output  max(1,$clog2(fo))  equals cycle_index[CW-1:$clog2(p/z)], or 0 when fo==1
- sweep_first  output  1  cycle_valid and low $clog2(p/z) bits of cycle_index all 0
- sweep_last  output  1  cycle_valid and low $clog2(p/z) bits of cycle_index all 1
- done  output  1  one-cycle pulse after the final handshake

Behaviour:
- Definitions: SW = $clog2(p/z); CW = $clog2(fo*p/z); LAST = fo*p/z-1.
- Reset (reset==0 at the clk edge) forces:
  - state IDLE, cycle_index 0, cycle_valid 0, done 0, start_err 0
  - sweepstart all 0, cfg_loaded 0, chunk pointer 0
  - Reset mid-RUN aborts the pass immediately; no done pulse is produced.
- State machine has two states, IDLE and RUN.
- Config port:
  - cfg_ready = (state==IDLE), combinational.
  - On cfg_valid && cfg_ready, cfg_data is written to chunk[ptr]; ptr advances and wraps from fo*z-1 to 0.
  - Writing chunk fo*z-1 sets cfg_loaded=1 on the next cycle.
  - Writing chunk 0 clears cfg_loaded (reload in progress).
  - If start and a config write occur in the same IDLE cycle, the config write completes first and start is evaluated against the pre-write cfg_loaded.
- IDLE:
  - start && cfg_loaded: go to RUN next cycle with cycle_index=0 and cycle_valid=1.
  - start && !cfg_loaded: start_err=1 for exactly one cycle; stay in IDLE.
- RUN:
  - cycle_valid=1 throughout.
  - Handshake = cycle_valid && cycle_ready.
  - On handshake with cycle_index<LAST: increment cycle_index.
  - Without handshake: hold cycle_index and all flags stable.
  - On handshake with cycle_index==LAST: next cycle state=IDLE, cycle_valid=0, cycle_index=0, done=1 for one cycle.
  - start is ignored in RUN.
- Back-to-back passes: start asserted during the done cycle (state IDLE) is accepted, so RUN restarts the following cycle. This gives one idle cycle between passes.
- sweepstart is frozen during RUN, because config writes are blocked.
- Single-pass throughput with cycle_ready tied high: LAST+1 cycles from the first valid to the last handshake.
- All outputs are registered except cfg_ready, sweep_first, sweep_last and sweep_index, which decode registered state.

Test Plan:
- Config load (defaults, SW=2, 16 chunks): write cfg_data=k%4 for k=0..15 with cfg_valid held high -> cfg_ready=1 each cycle, cfg_loaded rises the cycle after k=15, sweepstart=32'hE4E4E4E4.
- Full pass, cycle_ready=1: pulse start after load -> cycle_index 0..7 on 8 consecutive cycles; sweep_first at indices 0 and 4; sweep_last at 3 and 7; sweep_index 0,0,0,0,1,1,1,1; done pulses the cycle after index 7; busy=0 in that cycle.
- Backpressure: drop cycle_ready for 3 cycles while cycle_index=2 -> index stays 2 with cycle_valid=1 for 4 cycles, the pass completes in 11 cycles, and exactly one done pulse.
- Start before load (or after a chunk-0 rewrite) -> start_err pulses for 1 cycle, busy stays 0, cycle_valid stays 0.
- Config during RUN: cfg_valid=1 with cfg_data=3 at cycle_index 4 -> cfg_ready=0 and sweepstart unchanged; back-to-back start in the done cycle -> cycle_index=0 valid on the next cycle.
- Reset mid-RUN at cycle_index 5 -> next cycle cycle_valid=0, cycle_index=0, done=0, cfg_loaded=0, sweepstart=0; a subsequent start gives start_err=1.

Source files
------------

// File: rtl/interleaver_sequencer.sv
// Sequences one junction pass through interleaver_set: holds the chunk-serial sweepstart
// pattern and issues cycle_index 0..LAST under a valid/ready handshake, then pulses done.
module interleaver_sequencer #(
  parameter int fo = 2,
  parameter int fi = 4,
  parameter int p  = 32,
  parameter int n  = 8,
  parameter int z  = 8,
  localparam int SW   = $clog2(p / z),
  localparam int NCH  = fo * z,
  localparam int CW   = $clog2(fo * p / z),
  localparam int SIW  = (fo > 1) ? $clog2(fo) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_valid,
  input  logic [SW-1:0]     cfg_data,
  output logic              cfg_ready,
  output logic              cfg_loaded,
  output logic [SW*NCH-1:0] sweepstart,
  input  logic              start,
  output logic              start_err,
  output logic              busy,
  output logic [CW-1:0]     cycle_index,
  output logic              cycle_valid,
  input  logic              cycle_ready,
  output logic [SIW-1:0]    sweep_index,
  output logic              sweep_first,
  output logic              sweep_last,
  output logic              done
);

  localparam int PW   = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int LAST = fo * p / z - 1;

  if (fi < 1 || n < 1 || (p % z) != 0 || (p / z) < 2) begin : gBadParams
    $error("interleaver_sequencer: illegal parameter set");
  end

  typedef enum logic {IDLE, RUN} state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       idx_q, idx_d;
  logic                valid_q, valid_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic [SW*NCH-1:0]   sweep_q, sweep_d;
  logic                loaded_q, loaded_d;
  logic [PW-1:0]       ptr_q, ptr_d;
  logic                cfgWrite;
  logic                handshake;

  assign cfgWrite  = cfg_valid && (state_q == IDLE);
  assign handshake = valid_q && cycle_ready;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      sweep_q  <= '0;
      loaded_q <= 1'b0;
      ptr_q    <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      valid_q  <= valid_d;
      done_q   <= done_d;
      err_q    <= err_d;
      sweep_q  <= sweep_d;
      loaded_q <= loaded_d;
      ptr_q    <= ptr_d;
    end
  end

  // start is judged on loaded_q, so a same-cycle config write never enables it early.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    valid_d  = valid_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    sweep_d  = sweep_q;
    loaded_d = loaded_q;
    ptr_d    = ptr_q;

    if (cfgWrite) begin
      sweep_d[ptr_q*SW +: SW] = cfg_data;
      if (ptr_q == '0) loaded_d = 1'b0;
      if (ptr_q == PW'(NCH - 1)) begin
        loaded_d = 1'b1;
        ptr_d    = '0;
      end else begin
        ptr_d = ptr_q + 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        if (start && loaded_q) begin
          state_d = RUN;
          idx_d   = '0;
          valid_d = 1'b1;
        end else if (start) begin
          err_d = 1'b1;
        end
      end
      RUN: begin
        if (handshake) begin
          if (idx_q == CW'(LAST)) begin
            state_d = IDLE;
            idx_d   = '0;
            valid_d = 1'b0;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
        idx_d   = '0;
      end
    endcase
  end

  assign cfg_ready   = (state_q == IDLE);
  assign cfg_loaded  = loaded_q;
  assign sweepstart  = sweep_q;
  assign start_err   = err_q;
  assign busy        = (state_q == RUN);
  assign cycle_index = idx_q;
  assign cycle_valid = valid_q;
  assign done        = done_q;
  assign sweep_first = valid_q && (idx_q[SW-1:0] == '0);
  assign sweep_last  = valid_q && (&idx_q[SW-1:0]);

  if (fo > 1) begin : gSweepIdx
    assign sweep_index = idx_q[CW-1:SW];
  end else begin : gSweepIdxZero
    assign sweep_index = '0;
  end

endmodule

// File: tb/tb_interleaver_sequencer.sv
// Directed self-checking bench for interleaver_sequencer at default parameters
// (SW=2, 16 chunks, cycle_index 0..7, two sweeps of four).
module tb_interleaver_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        cfg_valid;
  logic [1:0]  cfg_data;
  logic        cfg_ready;
  logic        cfg_loaded;
  logic [31:0] sweepstart;
  logic        start;
  logic        start_err;
  logic        busy;
  logic [2:0]  cycle_index;
  logic        cycle_valid;
  logic        cycle_ready;
  logic [0:0]  sweep_index;
  logic        sweep_first;
  logic        sweep_last;
  logic        done;

  int errors = 0;
  int checks = 0;

  interleaver_sequencer dut (
    .clk(clk), .reset(reset),
    .cfg_valid(cfg_valid), .cfg_data(cfg_data), .cfg_ready(cfg_ready),
    .cfg_loaded(cfg_loaded), .sweepstart(sweepstart),
    .start(start), .start_err(start_err), .busy(busy),
    .cycle_index(cycle_index), .cycle_valid(cycle_valid), .cycle_ready(cycle_ready),
    .sweep_index(sweep_index), .sweep_first(sweep_first), .sweep_last(sweep_last),
    .done(done)
  );

  always #5 clk = ~clk;

  // Advance one clock; outputs are then sampled 1ns after the edge.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    int doneCount;
    int doneAt;
    reset = 1'b0; cfg_valid = 1'b0; cfg_data = '0; start = 1'b0; cycle_ready = 1'b1;
    applyStimulus();
    applyStimulus();

    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_valid", cycle_valid, 0);
    checkOutput("rst_index", cycle_index, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_err", start_err, 0);
    checkOutput("rst_loaded", cfg_loaded, 0);
    checkOutput("rst_sweepstart", sweepstart, 0);
    checkOutput("rst_cfg_ready", cfg_ready, 1);
    reset = 1'b1;
    applyStimulus();

    // Start before any load is rejected
    start = 1'b1;
    applyStimulus();
    start = 1'b0;
    checkOutput("early_err", start_err, 1);
    checkOutput("early_busy", busy, 0);
    checkOutput("early_valid", cycle_valid, 0);
    applyStimulus();
    checkOutput("early_err_clear", start_err, 0);

    // Config load: chunk k = k%4
    for (int k = 0; k < 16; k++) begin
      cfg_valid = 1'b1;
      cfg_data  = 2'(k % 4);
      checkOutput($sformatf("load_ready_%0d", k), cfg_ready, 1);
      checkOutput($sformatf("load_notyet_%0d", k), cfg_loaded, 0);
      applyStimulus();
    end
    cfg_valid = 1'b0;
    checkOutput("load_done", cfg_loaded, 1);
    checkOutput("load_pattern", sweepstart, 64'hE4E4E4E4);

    // Full pass with cycle_ready high
    start = 1'b1;
    applyStimulus();
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checkOutput($sformatf("pass_valid_%0d", i), cycle_valid, 1);
      checkOutput($sformatf("pass_index_%0d", i), cycle_index, 64'(i));
      checkOutput($sformatf("pass_first_%0d", i), sweep_first, ((i % 4) == 0) ? 1 : 0);
      checkOutput($sformatf("pass_last_%0d", i), sweep_last, ((i % 4) == 3) ? 1 : 0);
      checkOutput($sformatf("pass_sweep_%0d", i), sweep_index, 64'(i / 4));
      checkOutput($sformatf("pass_busy_%0d", i), busy, 1);
      checkOutput($sformatf("pass_nodone_%0d", i), done, 0);
      applyStimulus();
    end
    checkOutput("pass_done", done, 1);
    checkOutput("pass_done_busy", busy, 0);
    checkOutput("pass_done_valid", cycle_valid, 0);
    checkOutput("pass_done_index", cycle_index, 0);
    applyStimulus();
    checkOutput("pass_done_clear", done, 0);

    // Backpressure: hold at index 2 for three extra cycles
    start = 1'b1;
    applyStimulus();
    start = 1'b0;
    applyStimulus();
    applyStimulus();
    checkOutput("bp_index2", cycle_index, 2);
    cycle_ready = 1'b0;
    for (int j = 0; j < 3; j++) begin
      applyStimulus();
      checkOutput($sformatf("bp_hold_index_%0d", j), cycle_index, 2);
      checkOutput($sformatf("bp_hold_valid_%0d", j), cycle_valid, 1);
      checkOutput($sformatf("bp_hold_first_%0d", j), sweep_first, 0);
      checkOutput($sformatf("bp_hold_last_%0d", j), sweep_last, 0);
    end
    cycle_ready = 1'b1;
    doneCount = 0;
    doneAt    = -1;
    // Cycles 1..6 of the pass are already behind us; the done pulse should follow cycle 11.
    for (int t = 7; t <= 20; t++) begin
      applyStimulus();
      if (done) begin
        doneCount++;
        if (doneAt < 0) doneAt = t;
      end
    end
    checkOutput("bp_done_count", doneCount, 1);
    checkOutput("bp_pass_length", doneAt, 12);

    // Chunk-0 rewrite, then reload; start coinciding with the final write still errors
    cfg_valid = 1'b1;
    cfg_data  = 2'd0;
    applyStimulus();
    cfg_valid = 1'b0;
    checkOutput("rewrite_unloaded", cfg_loaded, 0);
    start = 1'b1;
    applyStimulus();
    start = 1'b0;
    checkOutput("rewrite_err", start_err, 1);
    checkOutput("rewrite_busy", busy, 0);
    checkOutput("rewrite_valid", cycle_valid, 0);
    for (int k = 1; k < 16; k++) begin
      cfg_valid = 1'b1;
      cfg_data  = 2'(k % 4);
      start     = (k == 15);
      applyStimulus();
    end
    cfg_valid = 1'b0;
    start     = 1'b0;
    checkOutput("same_cycle_err", start_err, 1);
    checkOutput("same_cycle_busy", busy, 0);
    checkOutput("reload_done", cfg_loaded, 1);
    checkOutput("reload_pattern", sweepstart, 64'hE4E4E4E4);
    applyStimulus();

    // Config attempt during RUN, then back-to-back start in the done cycle
    start = 1'b1;
    applyStimulus();
    start = 1'b0;
    for (int i = 0; i < 4; i++) applyStimulus();
    checkOutput("run_cfg_index4", cycle_index, 4);
    cfg_valid = 1'b1;
    cfg_data  = 2'd3;
    checkOutput("run_cfg_ready", cfg_ready, 0);
    applyStimulus();
    cfg_valid = 1'b0;
    checkOutput("run_cfg_pattern", sweepstart, 64'hE4E4E4E4);
    checkOutput("run_cfg_index5", cycle_index, 5);
    applyStimulus();
    applyStimulus();
    checkOutput("b2b_index7", cycle_index, 7);
    applyStimulus();
    checkOutput("b2b_done", done, 1);
    start = 1'b1;
    applyStimulus();
    start = 1'b0;
    checkOutput("b2b_valid", cycle_valid, 1);
    checkOutput("b2b_index0", cycle_index, 0);
    checkOutput("b2b_busy", busy, 1);

    // Reset mid-RUN at index 5
    for (int i = 0; i < 5; i++) applyStimulus();
    checkOutput("mid_index5", cycle_index, 5);
    reset = 1'b0;
    applyStimulus();
    reset = 1'b1;
    checkOutput("mid_rst_valid", cycle_valid, 0);
    checkOutput("mid_rst_index", cycle_index, 0);
    checkOutput("mid_rst_done", done, 0);
    checkOutput("mid_rst_loaded", cfg_loaded, 0);
    checkOutput("mid_rst_sweepstart", sweepstart, 0);
    checkOutput("mid_rst_busy", busy, 0);
    doneCount = 0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus();
      if (done) doneCount++;
    end
    checkOutput("mid_rst_no_done", doneCount, 0);
    start = 1'b1;
    applyStimulus();
    start = 1'b0;
    checkOutput("mid_rst_start_err", start_err, 1);
    checkOutput("mid_rst_start_busy", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
